bf_bus_arbiter: RTL
===================

Name: bf_bus_arbiter

Overview:
- Sequences the processor's single multiplexed external memory bus: an 8-bit tristate data/address bus plus `addr` and `write` strobes.
- Shares the bus between two requesters:
  - m0 is the BF core's load/store path.
  - m1 is a host/loader port used for program upload and debug peek/poke.
- Converts each req/ack transaction into the bus address phase and data phase, including read turnaround.
- Sits between the core/loader and the top-level `uo_out`/`uio_*` pins.

Parameters:
- DATA_W, 8, width of data, address and bus. Address and data share the bus, so they have the same width.
- WAIT_CYCLES, 1, number of read turnaround cycles with the bus released. Legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  arbitration enable; 0 blocks new grants
- m0_req  in  1  core request; held until m0_ack
- m0_we  in  1  core write (1) / read (0)
- m0_addr  in  DATA_W  core address
- m0_wdata  in  DATA_W  core write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  core read data, registered
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0, for the host/loader port
- bus_din  in  DATA_W  bus input path
- bus_dout  out  DATA_W  bus output path
- bus_oe  out  DATA_W  bus output enable, all-ones or all-zeros
- bus_addr  out  1  address-phase strobe
- bus_write  out  1  write strobe
- busy  out  1  state != IDLE
- gnt_id  out  1  master owning the current or last transaction

Behaviour:
- Reset (rst=1 at a clk edge), effective next cycle:
  - state=IDLE.
  - All acks 0, bus_addr=0, bus_write=0, bus_oe=0, bus_dout=0.
  - m0_rdata=0, m1_rdata=0, busy=0, gnt_id=0.
  - last_grant=1, so m0 wins the first tie.
  - Reset aborts any in-flight transaction: no ack is issued for it.
- States: IDLE, ADDR, WDATA, TURN, DONE.
- IDLE:
  - Bus idle: addr=0, write=0, oe=0.
  - If ena=1 and any req: grant via round-robin.
    - Single requester wins.
    - On a tie, the master != last_grant wins.
  - On grant: latch we/addr/wdata of the winner, set gnt_id and last_grant, go to ADDR.
  - Later changes on requester inputs are ignored until DONE.
- ADDR, 1 cycle:
  - bus_addr=1, bus_write=1, bus_oe=all-ones, bus_dout=latched addr.
  - Next state: WDATA if write, else TURN with counter=WAIT_CYCLES-1.
- WDATA, 1 cycle:
  - bus_addr=0, bus_write=1, bus_oe=all-ones, bus_dout=latched wdata.
  - Next state: DONE.
- TURN, WAIT_CYCLES cycles:
  - bus_addr=0, bus_write=0, bus_oe=0, bus_dout=0.
  - Counter decrements each cycle.
  - On the cycle with counter==0: bus_din is registered into the granted master's rdata, then state goes to DONE.
  - The other master's rdata is never modified.
- DONE, 1 cycle:
  - Bus idle; granted master's ack=1.
  - Always returns to IDLE, so there are no back-to-back grants without an IDLE cycle.
  - A req seen in DONE is not re-granted until IDLE.
- Latency from IDLE grant cycle T:
  - Write: ack at T+3.
  - Read: ack at T+2+WAIT_CYCLES.
  - Worst-case wait for a losing requester is one full transaction.
- Requester drops req before ack: the transaction still completes and the ack pulse is still emitted.
- ena=0 mid-transaction: no effect on the transaction in flight; only IDLE grants are gated.
- bus_dout is 0 whenever bus_oe=0.
- rdata holds its value until that master's next read completes.
- busy=0 only in IDLE.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high → all outputs 0, no ack; first grant after release goes to m0.
- m0 write, addr=0x12, wdata=0xA5:
  - T+1: bus_addr=1, bus_write=1, oe=0xFF, dout=0x12.
  - T+2: bus_addr=0, bus_write=1, dout=0xA5.
  - T+3: m0_ack=1, bus idle.
- m1 read, addr=0x40, WAIT_CYCLES=1, bus_din=0x3C during TURN:
  - T+1: address phase.
  - T+2: oe=0x00.
  - T+3: m1_ack=1, m1_rdata=0x3C, m0_rdata unchanged.
- WAIT_CYCLES=3 read, bus_din=0x11,0x22,0x77 on the three TURN cycles → oe=0 for 3 cycles, rdata=0x77, ack at T+5.
- Both reqs held continuously with writes → grants alternate m0,m1,m0,m1, 4 cycles per transaction; gnt_id toggles; no ack to the wrong master.
- Abort and gating:
  - rst=1 during WDATA → IDLE next cycle, no ack, oe=0.
  - ena=0 with m0_req=1 → stays IDLE, busy=0.
  - ena→1 → ADDR next cycle.

Source files
------------

// File: rtl/bf_bus_arbiter.sv
// bf_bus_arbiter: two-master arbiter/sequencer for the shared 8-bit
// multiplexed external memory bus (address and data on the same pins).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ena             gates new grants in IDLE only
//   m0_* / m1_*     req/we/addr/wdata in, ack pulse + registered rdata out
//                   (m0 = core load/store, m1 = host/loader)
//   bus_din         bus input path (sampled on the last turnaround cycle)
//   bus_dout/bus_oe bus output path and all-ones/all-zeros output enable
//   bus_addr        address-phase strobe
//   bus_write       write strobe (also asserted in the address phase)
//   busy            high whenever a transaction is in flight
//   gnt_id          master owning the current or most recent transaction
module bf_bus_arbiter #(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1   // 1..7 turnaround cycles
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic [DATA_W-1:0] bus_din,
    output logic [DATA_W-1:0] bus_dout,
    output logic [DATA_W-1:0] bus_oe,
    output logic              bus_addr,
    output logic              bus_write,
    output logic              busy,
    output logic              gnt_id
);

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_TURN, S_DONE} state_t;

    localparam logic [2:0] TURN_INIT = 3'(WAIT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [2:0]      turn_cnt;
    req_t            lat;          // winner's request, frozen until DONE
    req_t [1:0]      mreq;
    logic [1:0]      req_vec;
    logic            last_grant;
    logic            gnt_q;
    logic            gnt_vld;
    logic            gnt_sel;
    logic            oe_all;
    logic            turn_last;

    assign req_vec = {m1_req, m0_req};
    assign mreq[0] = {m0_we, m0_addr, m0_wdata};
    assign mreq[1] = {m1_we, m1_addr, m1_wdata};

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        gnt_vld = ena && (req_vec != 2'b00);
        gnt_sel = (&req_vec) ? ~last_grant : req_vec[1];
    end

    assign turn_last = (state == S_TURN) && (turn_cnt == 3'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (gnt_vld) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = lat.we ? S_WDATA : S_TURN;
            S_WDATA: state_nxt = S_DONE;
            S_TURN:  if (turn_cnt == 3'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: request latch, grant history, turnaround counter, read data
    always_ff @(posedge clk) begin
        if (rst) begin
            lat        <= '0;
            last_grant <= 1'b1;   // makes m0 win the first tie
            gnt_q      <= 1'b0;
            turn_cnt   <= 3'd0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (state == S_IDLE && gnt_vld) begin
                lat        <= mreq[gnt_sel];
                gnt_q      <= gnt_sel;
                last_grant <= gnt_sel;
            end
            if (state == S_ADDR)
                turn_cnt <= TURN_INIT;
            else if (state == S_TURN && turn_cnt != 3'd0)
                turn_cnt <= turn_cnt - 3'd1;
            // Only the granted master's read data ever changes.
            if (turn_last) begin
                if (gnt_q) m1_rdata <= bus_din;
                else       m0_rdata <= bus_din;
            end
        end
    end

    // Output logic: bus driven only in ADDR/WDATA, dout forced to 0 otherwise
    always_comb begin
        bus_addr  = 1'b0;
        bus_write = 1'b0;
        oe_all    = 1'b0;
        bus_dout  = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        unique case (state)
            S_ADDR: begin
                bus_addr  = 1'b1;
                bus_write = 1'b1;
                oe_all    = 1'b1;
                bus_dout  = lat.addr;
            end
            S_WDATA: begin
                bus_write = 1'b1;
                oe_all    = 1'b1;
                bus_dout  = lat.wdata;
            end
            S_DONE: begin
                m0_ack = ~gnt_q;
                m1_ack = gnt_q;
            end
            default: ;
        endcase
    end

    assign bus_oe = {DATA_W{oe_all}};
    assign busy   = (state != S_IDLE);
    assign gnt_id = gnt_q;

endmodule
